// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle RV32I control sequencer.
// Walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK) and drives the
// datapath strobes, PC/IR load, regfile write and memory handshakes.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap instead of
// retiring as NOPs.

package cpu_package;
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instruction_type_t;
endpackage

module cpu_control_fsm
    import cpu_package::*;
#(
    parameter int unsigned RETIRE_CNT_W = 32,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [31:0]             i_instruction,
    input  logic                    i_imem_ready,
    input  logic                    i_dmem_ready,
    input  logic                    i_branch_taken,
    output logic                    o_imem_req,
    output logic                    o_ir_write,
    output logic                    o_dmem_req,
    output logic                    o_dmem_we,
    output instruction_type_t       o_instruction_type,
    output logic                    o_alu_src_imm,
    output logic [1:0]              o_pc_src,
    output logic                    o_pc_write,
    output logic                    o_reg_write,
    output logic [1:0]              o_wb_sel,
    output logic                    o_illegal,
    output logic                    o_mem_timeout,
    output logic [RETIRE_CNT_W-1:0] o_retired,
    output logic [2:0]              o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Counter only ever holds up to MEM_TIMEOUT-1; reaching the limit traps.
    localparam int unsigned WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t                  r_state;
    logic [RETIRE_CNT_W-1:0] r_retired;
    logic                    r_illegal;
    logic                    r_mem_timeout;
    logic [WD_W-1:0]         r_wd_cnt;

    logic [6:0]        w_opcode;
    instruction_type_t w_type;
    logic              w_legal;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_branch;
    logic              w_is_jal;
    logic              w_is_jalr;
    logic              w_is_fence;
    logic              w_stall;
    logic              w_wd_expire;
    logic              w_unused_bits;

    assign w_opcode      = i_instruction[6:0];
    assign w_unused_bits = ^i_instruction[31:7];

    // Classify the opcode and derive the immediate format.
    always_comb begin
        w_type      = R_TYPE;
        w_legal     = 1'b1;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_is_fence  = 1'b0;
        case (w_opcode)
            OPC_OP:     w_type = R_TYPE;
            OPC_OPIMM:  w_type = I_TYPE;
            OPC_LOAD:   begin w_type = I_TYPE; w_is_load  = 1'b1; end
            OPC_JALR:   begin w_type = I_TYPE; w_is_jalr  = 1'b1; end
            OPC_FENCE:  begin w_type = I_TYPE; w_is_fence = 1'b1; end
            OPC_STORE:  begin w_type = S_TYPE; w_is_store = 1'b1; end
            OPC_BRANCH: begin w_type = B_TYPE; w_is_branch = 1'b1; end
            OPC_LUI:    w_type = U_TYPE;
            OPC_AUIPC:  w_type = U_TYPE;
            OPC_JAL:    begin w_type = J_TYPE; w_is_jal = 1'b1; end
            default:    w_legal = 1'b0;
        endcase
    end

    // A stall is any cycle with a request outstanding and no ready.
    assign w_stall = ((r_state == S_FETCH)  && !i_imem_ready) ||
                     ((r_state == S_MEMORY) && !i_dmem_ready);
    assign w_wd_expire = (MEM_TIMEOUT != 0) && w_stall &&
                         (r_wd_cnt == WD_W'(MEM_TIMEOUT - 1));

    // Sequencer: state, retire counter, sticky flags and handshake watchdog.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_retired     <= '0;
            r_illegal     <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_wd_cnt      <= '0;
        end else begin
            if (w_stall) r_wd_cnt <= r_wd_cnt + WD_W'(1);
            else         r_wd_cnt <= '0;

            if (w_wd_expire) begin
                r_state       <= S_TRAP;
                r_mem_timeout <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE:  r_state <= S_FETCH;
                    S_FETCH: if (i_imem_ready) r_state <= S_DECODE;
                    S_DECODE: begin
                        if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
`else
                            r_state   <= S_FETCH;
                            r_retired <= r_retired + RETIRE_CNT_W'(1);
`endif
                        end else begin
                            r_state <= S_EXECUTE;
                        end
                    end
                    S_EXECUTE: begin
                        if (w_is_branch || w_is_fence) begin
                            r_state   <= S_FETCH;
                            r_retired <= r_retired + RETIRE_CNT_W'(1);
                        end else if (w_is_load || w_is_store) begin
                            r_state <= S_MEMORY;
                        end else begin
                            r_state <= S_WRITEBACK;
                        end
                    end
                    S_MEMORY: begin
                        if (i_dmem_ready) begin
                            if (w_is_store) begin
                                r_state   <= S_FETCH;
                                r_retired <= r_retired + RETIRE_CNT_W'(1);
                            end else begin
                                r_state <= S_WRITEBACK;
                            end
                        end
                    end
                    S_WRITEBACK: begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + RETIRE_CNT_W'(1);
                    end
                    S_TRAP:  r_state <= S_TRAP;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Datapath controls decoded from state and opcode; all quiet while in reset.
    always_comb begin
        o_imem_req         = 1'b0;
        o_ir_write         = 1'b0;
        o_dmem_req         = 1'b0;
        o_dmem_we          = 1'b0;
        o_instruction_type = R_TYPE;
        o_alu_src_imm      = 1'b0;
        o_pc_src           = 2'd0;
        o_pc_write         = 1'b0;
        o_reg_write        = 1'b0;
        o_wb_sel           = 2'd0;
        if (!i_rst) begin
            case (r_state)
                S_FETCH: begin
                    o_imem_req = 1'b1;
                    if (i_imem_ready) begin
                        o_ir_write = 1'b1;
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'd0;
                    end
                end
                S_DECODE: o_instruction_type = w_type;
                S_EXECUTE: begin
                    o_instruction_type = w_type;
                    o_alu_src_imm      = (w_type != R_TYPE) && (w_type != B_TYPE);
                    if (w_is_branch) begin
                        o_pc_write = i_branch_taken;
                        o_pc_src   = 2'd1;
                    end else if (w_is_jal) begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'd1;
                    end else if (w_is_jalr) begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'd2;
                    end
                end
                S_MEMORY: begin
                    o_instruction_type = w_type;
                    o_dmem_req         = 1'b1;
                    o_dmem_we          = w_is_store;
                end
                S_WRITEBACK: begin
                    o_instruction_type = w_type;
                    o_reg_write        = 1'b1;
                    if (w_is_load)                  o_wb_sel = 2'd1;
                    else if (w_is_jal || w_is_jalr) o_wb_sel = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign o_illegal     = r_illegal;
    assign o_mem_timeout = r_mem_timeout;
    assign o_retired     = r_retired;
    assign o_state       = r_state;

endmodule
